// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package mult_pkg;

    localparam int MULT_W = 8;
    localparam int CNT_W  = 3;

    // Counter value on the final iteration.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/carry_lookahead_adder_8.sv
// Combinational 8-bit carry lookahead adder.
module carry_lookahead_adder_8 (
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] gen;
    logic [7:0] prop;
    logic [8:0] carry;
    logic       term;
    logic       prop_run;

    assign gen  = in1 & in2;
    assign prop = in1 ^ in2;

    // Each carry is a flat sum of generate terms gated by the propagate chain above them.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        carry    = '0;
        term     = 1'b0;
        prop_run = 1'b0;
        carry[0] = cin;
        for (int i = 0; i < 8; i++) begin
            term     = gen[i];
            prop_run = prop[i];
            for (int j = 7; j >= 0; j--) begin
                if (j < i) begin
                    term     = term | (prop_run & gen[j]);
                    prop_run = prop_run & prop[j];
                end
            end
            carry[i+1] = term | (prop_run & cin);
        end
    end

    assign sum  = prop ^ carry[7:0];
    assign cout = carry[8];

endmodule

// File: rtl/shift_add_multiplier_8.sv
// Sequential unsigned 8x8 multiplier: one conditional add and right shift per clock.
module shift_add_multiplier_8
    import mult_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product
);

    mult_state_t       state_q, state_d;
    logic [MULT_W-1:0] mcand_q, mcand_d;
    logic [MULT_W-1:0] acc_q,   acc_d;
    logic [MULT_W-1:0] q_q,     q_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic [MULT_W-1:0] add_in2;
    logic [MULT_W-1:0] add_sum;
    logic              add_cout;

    // Add the multiplicand only when the current multiplier bit is set.
    assign add_in2 = q_q[0] ? mcand_q : '0;

    carry_lookahead_adder_8 u_adder (
        .in1  (acc_q),
        .in2  (add_in2),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state and datapath update for the control FSM.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    q_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The adder carry lands in bit 15 after the shift, so no overflow is lost.
                {acc_d, q_d} = {add_cout, add_sum, q_q[MULT_W-1:1]};
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = {acc_q, q_q};

endmodule

// File: tb/tb_shift_add_multiplier_8.sv
// Self-checking bench for shift_add_multiplier_8 against a plain a*b model.
module tb_shift_add_multiplier_8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    shift_add_multiplier_8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one pair, optionally jam new operands during RUN and stall in DONE.
    task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input int stall,
                          input bit jam, output int acc_cyc);
        int          lat;
        logic [15:0] exp;
        exp = 16'(ai) * 16'(bi);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a         = ai;
        b         = bi;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!jam) in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (jam) begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 32'(lat), 32'd8);
        check("product", 32'(product), 32'(exp));
        check("in_ready_done", 32'(in_ready), 32'd0);
        repeat (stall) begin
            @(posedge clk);
            #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_product", 32'(product), 32'(exp));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready), 32'd1);
        check("idle_product", 32'(product), 32'(exp));
    endtask

    initial begin
        int c0;
        int c1;
        int seen;
        int stall;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        #12;
        check("rst_product", 32'(product), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases, including the back-to-back initiation interval.
        run_op(8'd13, 8'd11, 0, 1'b0, c0);
        run_op(8'd3, 8'd5, 0, 1'b0, c1);
        check("initiation_interval", 32'(c1 - c0), 32'd10);
        run_op(8'hFF, 8'hFF, 0, 1'b0, c0);
        run_op(8'h80, 8'h02, 0, 1'b0, c0);
        run_op(8'h00, 8'hA5, 0, 1'b0, c0);
        run_op(8'hA5, 8'h00, 0, 1'b0, c0);
        run_op(8'd57, 8'd201, 5, 1'b0, c0);
        run_op(8'd99, 8'd7, 2, 1'b1, c0);

        // Reset in the middle of RUN discards the operation.
        check("pre_rst_ready", 32'(in_ready), 32'd1);
        a        = 8'h77;
        b        = 8'h55;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrun_rst_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_ready", 32'(in_ready), 32'd1);
        check("midrun_rst_product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("no_valid_after_rst", 32'(seen), 32'd0);
        run_op(8'd200, 8'd200, 0, 1'b0, c0);

        // Random pairs with occasional stalls and jammed inputs.
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op(8'($urandom), 8'($urandom), stall, ($urandom_range(0, 7) == 0), c0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
